// File: rtl/photo_transition_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | photo_transition_engine: split-curtain open/hold/close effect on a VGA    |
// | raster in front of an RGB444 image ROM.                 Revision: 1.0     |
// +--------------------------------------------------------------------------+
module photo_transition_engine #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int SCALE_SH = 1,
  parameter int ADDR_W   = 17,
  parameter int STEP_W   = 4,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic              valid_in,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [11:0]       rgb,
  output logic              valid_out,
  output logic [1:0]        state,
  output logic              busy
);

  localparam int c_HALF_W  = IMG_W / 2;
  localparam int c_HALF_H  = IMG_H / 2;
  localparam int c_LIM_MAX = (c_HALF_W > c_HALF_H) ? c_HALF_W : c_HALF_H;
  localparam int c_OFF_W   = $clog2(c_LIM_MAX + 1);
  localparam int c_SUM_W   = ((c_OFF_W > STEP_W) ? c_OFF_W : STEP_W) + 1;
  localparam int c_CW      = ((c_OFF_W > 10) ? c_OFF_W : 10) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OPEN  = 2'b01,
    S_HOLD  = 2'b11,
    S_CLOSE = 2'b10
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_OFF_W-1:0]   r_off, w_off_nxt, w_lim;
  logic                 r_run, w_run_nxt;
  logic                 r_axis, w_axis_nxt;
  logic [1:0]           r_cur_mode, w_cur_mode_nxt;
  logic [c_SUM_W-1:0]   w_off_ext, w_step_ext, w_sum;

  assign w_lim      = r_axis ? c_OFF_W'(c_HALF_H) : c_OFF_W'(c_HALF_W);
  assign w_off_ext  = c_SUM_W'(r_off);
  assign w_step_ext = c_SUM_W'(step);
  assign w_sum      = w_off_ext + w_step_ext;

  always_comb begin
    w_state_nxt    = r_state;
    w_off_nxt      = r_off;
    w_run_nxt      = r_run;
    w_axis_nxt     = r_axis;
    w_cur_mode_nxt = r_cur_mode;
    case (r_state)
      S_IDLE: begin
        w_off_nxt = '0;
        if (start) begin
          w_state_nxt    = S_OPEN;
          w_run_nxt      = 1'b1;
          w_cur_mode_nxt = mode;
          w_axis_nxt     = (mode == 2'b01);
        end
      end
      default: begin
        // A start pulse only pauses/resumes; it swallows any coincident tick.
        if (start) begin
          w_run_nxt = ~r_run;
        end else if (tick && r_run) begin
          case (r_state)
            S_OPEN: begin
              if (w_sum >= c_SUM_W'(w_lim)) begin
                w_off_nxt   = w_lim;
                w_state_nxt = S_HOLD;
              end else begin
                w_off_nxt = w_sum[c_OFF_W-1:0];
              end
            end
            S_HOLD: w_state_nxt = S_CLOSE;
            S_CLOSE: begin
              if (w_off_ext <= w_step_ext) begin
                w_off_nxt = '0;
                if (r_cur_mode == 2'b10) begin
                  w_state_nxt = S_OPEN;
                  w_axis_nxt  = ~r_axis;
                end else begin
                  w_state_nxt = S_IDLE;
                end
              end else begin
                w_off_nxt = r_off - w_step_ext[c_OFF_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_off      <= '0;
      r_run      <= 1'b0;
      r_axis     <= 1'b0;
      r_cur_mode <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_off      <= w_off_nxt;
      r_run      <= w_run_nxt;
      r_axis     <= w_axis_nxt;
      r_cur_mode <= w_cur_mode_nxt;
    end
  end

  logic [9:0]        w_x, w_y;
  logic [c_CW-1:0]   w_pos, w_half, w_fwd, w_back, w_pos_m, w_xs, w_ys;
  logic              w_near, w_black;
  logic [31:0]       w_addr_full;

  assign w_x    = h_cnt >> SCALE_SH;
  assign w_y    = v_cnt >> SCALE_SH;
  assign w_pos  = r_axis ? c_CW'(w_y) : c_CW'(w_x);
  assign w_half = r_axis ? c_CW'(c_HALF_H) : c_CW'(c_HALF_W);
  assign w_near = (w_pos < w_half);
  assign w_fwd  = w_pos + c_CW'(r_off);
  assign w_back = w_pos - c_CW'(r_off);
  // Each half slides away from the centre line; pixels pulled across it go black.
  assign w_pos_m = w_near ? w_fwd : w_back;
  assign w_black = (r_state == S_HOLD) ||
                   (w_near ? (w_fwd >= w_half) : (w_back < w_half));
  assign w_xs    = r_axis ? c_CW'(w_x) : w_pos_m;
  assign w_ys    = r_axis ? w_pos_m : c_CW'(w_y);
  assign w_addr_full = 32'(w_ys) * 32'(IMG_W) + 32'(w_xs);

  logic [ADDR_W-1:0] r_rom_addr;
  logic [ROM_LAT:0]  r_vld_d, r_blk_d;
  logic [11:0]       r_rgb;
  logic              r_vld_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_addr <= '0;
      r_vld_d    <= '0;
      r_blk_d    <= '0;
      r_rgb      <= '0;
      r_vld_out  <= 1'b0;
    end else begin
      r_rom_addr <= ADDR_W'(w_addr_full);
      r_vld_d    <= {r_vld_d[ROM_LAT-1:0], valid_in};
      r_blk_d    <= {r_blk_d[ROM_LAT-1:0], w_black};
      r_rgb      <= (r_vld_d[ROM_LAT] && !r_blk_d[ROM_LAT]) ? rom_data : 12'h000;
      r_vld_out  <= r_vld_d[ROM_LAT];
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rgb       = r_rgb;
  assign valid_out = r_vld_out;
  assign state     = r_state;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_photo_transition_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_photo_transition_engine: randomized bench with a behavioural model.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_photo_transition_engine;

  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int SCALE_SH = 1;
  localparam int ADDR_W   = 17;
  localparam int STEP_W   = 4;
  localparam int ROM_LAT  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tick = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [STEP_W-1:0] step = '0;
  logic              valid_in = 1'b0;
  logic [9:0]        h_cnt = '0;
  logic [9:0]        v_cnt = '0;
  logic [11:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rgb;
  logic              valid_out;
  logic [1:0]        state;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  photo_transition_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SH(SCALE_SH),
    .ADDR_W(ADDR_W), .STEP_W(STEP_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .mode(mode), .step(step),
    .valid_in(valid_in), .h_cnt(h_cnt), .v_cnt(v_cnt), .rom_data(rom_data),
    .rom_addr(rom_addr), .rgb(rgb), .valid_out(valid_out), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'h5A3;
    return t[11:0] ^ 12'(a >> 9);
  endfunction

  // External ROM: content is a hash of the address, ROM_LAT cycles late.
  logic [11:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 opening, 2 holding, 3 closing.
  int          m_phase, m_off, m_cm, exp_addr;
  bit          m_run, m_ax;
  logic [11:0] q_rgb [$];
  bit          q_vld [$];

  function automatic logic [1:0] phase_code(input int p);
    case (p)
      1:       return 2'b01;
      2:       return 2'b11;
      3:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_off = 0; m_cm = 0; m_run = 0; m_ax = 0; exp_addr = 0;
    q_rgb.delete(); q_vld.delete();
    for (int i = 0; i <= ROM_LAT; i++) begin
      q_rgb.push_back(12'h000);
      q_vld.push_back(1'b0);
    end
  endtask

  task automatic pixel_expect(input bit vin, input int h, input int v);
    int x, y, xs, ys, half, a;
    bit blk;
    x = h >> SCALE_SH; y = v >> SCALE_SH;
    xs = x; ys = y; blk = 0;
    if (!m_ax) begin
      half = IMG_W / 2;
      if (x < half) begin xs = x + m_off; blk = (xs >= half); end
      else          begin xs = x - m_off; blk = (xs < half);  end
    end else begin
      half = IMG_H / 2;
      if (y < half) begin ys = y + m_off; blk = (ys >= half); end
      else          begin ys = y - m_off; blk = (ys < half);  end
    end
    if (m_phase == 2) blk = 1;
    a = (ys * IMG_W + xs) % (1 << ADDR_W);
    exp_addr = a;
    q_rgb.push_back((vin && !blk) ? rom_fn(ADDR_W'(a)) : 12'h000);
    q_vld.push_back(vin);
  endtask

  task automatic model_step(input bit t, input bit s, input logic [1:0] md, input int st);
    int lim;
    if (m_phase == 0) begin
      m_off = 0;
      if (s) begin
        m_phase = 1; m_run = 1; m_cm = int'(md); m_ax = (md == 2'b01);
      end
    end else if (s) begin
      m_run = !m_run;
    end else if (t && m_run) begin
      lim = m_ax ? IMG_H / 2 : IMG_W / 2;
      case (m_phase)
        1: begin
          m_off = (m_off + st > lim) ? lim : m_off + st;
          if (m_off == lim) m_phase = 2;
        end
        2: m_phase = 3;
        default: begin
          m_off = (m_off - st < 0) ? 0 : m_off - st;
          if (m_off == 0) begin
            if (m_cm == 2) begin m_phase = 1; m_ax = !m_ax; end
            else m_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input bit t, input bit s, input logic [1:0] md, input int st,
                     input bit vin, input int h, input int v);
    logic [11:0] er;
    bit ev;
    tick = t; start = s; mode = md; step = STEP_W'(st);
    valid_in = vin; h_cnt = 10'(h); v_cnt = 10'(v);
    pixel_expect(vin, h, v);
    model_step(t, s, md, st);
    @(posedge clk); #1;
    er = q_rgb.pop_front();
    ev = q_vld.pop_front();
    chk("state", 32'(state), 32'(phase_code(m_phase)));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    chk("rgb", 32'(rgb), 32'(er));
    chk("valid_out", 32'(valid_out), 32'(ev));
  endtask

  task automatic rcyc(input bit t, input bit s, input logic [1:0] md, input int st);
    cyc(t, s, md, st, $urandom_range(0, 7) != 0, $urandom_range(0, 639), $urandom_range(0, 479));
  endtask

  task automatic do_reset();
    rst = 1'b0; tick = 0; start = 0; valid_in = 0;
    #1;
    model_reset();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_state", 32'(state), 32'h0);
    rst = 1'b1;
  endtask

  int idle_seen;

  initial begin
    do_reset();

    // Idle passthrough: address after one cycle, pixel after ROM_LAT+2.
    cyc(0, 0, 2'b00, 0, 1, 10, 4);
    chk("idle_addr_645", 32'(rom_addr), 32'd645);
    for (int i = 0; i <= ROM_LAT; i++) cyc(0, 0, 2'b00, 0, 1, 10, 4);
    chk("idle_rgb_645", 32'(rgb), 32'(rom_fn(17'd645)));

    // Horizontal run with step 8: 20 ticks open, hold, 20 ticks close.
    rcyc(0, 1, 2'b00, 8);
    for (int i = 0; i < 20; i++) rcyc(1, 0, 2'b00, 8);
    chk("open20_hold", 32'(state), 32'h3);
    for (int i = 0; i < 6; i++) rcyc(0, 0, 2'b01, 8);
    rcyc(1, 0, 2'b00, 8);
    for (int i = 0; i < 20; i++) rcyc(1, 0, 2'b00, 8);
    chk("close20_idle", 32'(state), 32'h0);

    // Offset 40: left-half address shift and right-half black pixel.
    do_reset();
    rcyc(0, 1, 2'b00, 8);
    for (int i = 0; i < 5; i++) rcyc(1, 0, 2'b00, 8);
    cyc(0, 0, 2'b00, 8, 1, 2, 20);
    chk("off40_addr", 32'(rom_addr), 32'd3241);
    cyc(0, 0, 2'b00, 8, 1, 322, 20);
    for (int i = 0; i <= ROM_LAT; i++) cyc(0, 0, 2'b00, 8, 1, 2, 20);
    chk("off40_black", 32'(rgb), 32'h0);
    chk("off40_valid", 32'(valid_out), 32'h1);

    // Start coinciding with tick pauses without stepping; next start resumes.
    cyc(1, 1, 2'b00, 8, 1, 2, 20);
    cyc(1, 0, 2'b00, 8, 1, 2, 20);
    chk("pause_addr", 32'(rom_addr), 32'd3241);
    cyc(0, 1, 2'b00, 8, 1, 2, 20);
    cyc(1, 0, 2'b00, 8, 1, 2, 20);
    cyc(0, 0, 2'b00, 8, 1, 2, 20);
    chk("resume_addr", 32'(rom_addr), 32'd3249);

    // Saturation at the limit, then asynchronous reset mid-animation.
    do_reset();
    rcyc(0, 1, 2'b11, 15);
    for (int i = 0; i < 10; i++) rcyc(1, 0, 2'b00, 15);
    chk("off150_open", 32'(state), 32'h1);
    rcyc(1, 0, 2'b00, 15);
    chk("sat_hold", 32'(state), 32'h3);
    do_reset();

    // Alternating mode never returns to idle.
    rcyc(0, 1, 2'b10, 15);
    idle_seen = 0;
    for (int i = 0; i < 80; i++) begin
      rcyc($urandom_range(0, 3) != 0, 0, 2'($urandom_range(0, 3)), 15);
      if (state == 2'b00) idle_seen++;
    end
    chk("alt_never_idle", 32'(idle_seen), 32'h0);

    // Random soak with occasional resets, step=0 stalls and ignored mode changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      rcyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 15));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/photo_transition_engine.md
PHOTO_TRANSITION_ENGINE -- requirements
Module: photo_transition_engine

Interface
REQ-001 Parameter IMG_W, default 320, meaning source image width in pixels.
REQ-002 Parameter IMG_H, default 240, meaning source image height in pixels.
REQ-003 Parameter SCALE_SH, default 1, meaning right-shift applied to h_cnt/v_cnt to get image coordinates (pixel doubling).
REQ-004 Parameter ADDR_W, default 17, meaning ROM address width, SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 Parameter STEP_W, default 4, meaning width of the step input.
REQ-006 Parameter ROM_LAT, default 1, meaning image ROM read latency in clk cycles (1..4).
REQ-007 Port clk, input, 1, the single clock for all logic.
REQ-008 Port rst, input, 1, reset that is asynchronous and active-low, clearing all state while 0.
REQ-009 Port tick, input, 1, single-cycle animation step enable.
REQ-010 Port start, input, 1, single-cycle (already one-pulsed) run/pause request.
REQ-011 Port mode, input, 2, 00 horizontal split, 01 vertical split, 10 alternating continuous, 11 treated as 00.
REQ-012 Port step, input, STEP_W, offset increment per tick.
REQ-013 Port valid_in / h_cnt[9:0] / v_cnt[9:0], input, raster position and active-area flag from VGA timing.
REQ-014 Port rom_data, input, 12, RGB444 pixel returned by the image ROM.
REQ-015 Port rom_addr, output, ADDR_W, registered ROM read address.
REQ-016 Port rgb, output, 12, registered {R,G,B} to VGA pins.
REQ-017 Port valid_out, output, 1, rgb is an active-area pixel.
REQ-018 Port state, output, 2, current FSM state; busy, output, 1, high in any state but IDLE.

Function
REQ-019 FSM states SHALL be IDLE=00, OPEN=01, HOLD=11, CLOSE=10.
REQ-020 Internal regs: off (offset, saturating), run (flag), axis (0 horizontal, 1 vertical), cur_mode (latched).
REQ-021 Limit L SHALL be IMG_W/2 when axis=0 and IMG_H/2 when axis=1.
REQ-022 IDLE: off=0; on start go OPEN, set run=1, latch cur_mode=mode, axis=(mode==01).
REQ-023 In non-IDLE states, start SHALL toggle run and no step SHALL occur that cycle, even if tick is also high.
REQ-024 OPEN, tick&run: off <= min(off+step, L); when off reaches L go HOLD on the same update.
REQ-025 HOLD: off stays L, display fully black; next tick&run goes CLOSE.
REQ-026 CLOSE, tick&run: off <= max(off-step, 0); on reaching 0 go IDLE, or if cur_mode=10 go OPEN with axis inverted.
REQ-027 step=0 SHALL stall the animation without error; mode changes outside IDLE SHALL be ignored.
REQ-028 Coordinates: x=h_cnt>>SCALE_SH, y=v_cnt>>SCALE_SH; horizontal: x<IMG_W/2 gives xs=x+off, black if xs>=IMG_W/2; else xs=x-off, black if xs<IMG_W/2; ys=y.
REQ-029 Vertical mapping SHALL be identical with y, IMG_H, ys; xs=x.
REQ-030 rom_addr SHALL be ys*IMG_W+xs computed without truncation before ADDR_W, registered one cycle after h_cnt/v_cnt.
REQ-031 Black flag and valid_in SHALL be delayed ROM_LAT+1 cycles to align with rom_data; rgb = 0 if black or delayed valid is 0, else rom_data.
REQ-032 Total latency h_cnt -> rgb SHALL be ROM_LAT+2 cycles, rgb/valid_out both registered.

Reset
REQ-033 While rst=0: state=IDLE, off=0, run=0, axis=0, cur_mode=00, rom_addr=0, rgb=0, valid_out=0, busy=0, all delay-line stages cleared.
REQ-034 Reset asserted mid-animation SHALL abort immediately; after release the first start behaves as from power-up.

Verification
REQ-035 Reset, valid_in=1, h_cnt=10, v_cnt=4, IDLE -> rom_addr=2*320+5=645 after 1 cycle, rgb=rom_data after ROM_LAT+2.
REQ-036 mode=00, start, step=8, 20 ticks -> off 8,16..160, state HOLD after tick 20, all rgb=0; 20 more ticks after HOLD tick -> IDLE.
REQ-037 mode=00, off=40, h_cnt=2 (x=1) -> rom_addr=y*320+41; h_cnt=322 (x=161) -> black since xs=121<160.
REQ-038 mode=10 -> horizontal OPEN/HOLD/CLOSE then vertical OPEN with L=120, never IDLE until reset.
REQ-039 start with tick in same cycle during OPEN -> run=0, off unchanged; next start resumes stepping.
REQ-040 step=15, off=150, OPEN, tick -> off=160 (saturated), state HOLD; rst pulse low -> IDLE, rgb=0, valid_out=0.
